// File: rtl/time_unit_counter.sv
// Modulo-N up/down time-unit counter (seconds, minutes or hours) with a
// synchronous checked load, registered wrap/error pulses, an optional
// 12-hour display mapping, BCD digit outputs and a gated display bus.
module time_unit_counter #(
    parameter int unsigned WIDTH     = 5,
    parameter int unsigned MODULUS   = 24,
    parameter int unsigned HOUR_MODE = 1
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             tick,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             enable,
    input  logic             mode_12h,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] databus,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones,
    output logic             pm,
    output logic             carry,
    output logic             borrow,
    output logic             load_err
);

    // One guard bit above the count so MODULUS == 2^WIDTH still compares cleanly.
    localparam int unsigned LAST    = MODULUS - 1;
    localparam int unsigned TWELVE_I = 12;
    localparam logic [WIDTH:0] MOD_EXT  = MODULUS[WIDTH:0];
    localparam logic [WIDTH:0] MOD_LAST = LAST[WIDTH:0];
    localparam logic [WIDTH:0] TWELVE   = TWELVE_I[WIDTH:0];
    localparam logic [WIDTH:0] ONE      = {{WIDTH{1'b0}}, 1'b1};

    // BCD conversion width: enough for values up to 99 and for the widened count.
    localparam int unsigned DW = (WIDTH + 1 > 7) ? WIDTH + 1 : 7;

    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             load_err_q, load_err_d;

    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   data_ext;
    logic [WIDTH:0]   count_inc;
    logic [WIDTH:0]   count_dec;
    logic             hour12;
    logic [WIDTH:0]   disp_ext;
    logic [DW-1:0]    disp_wide;
    logic [DW-1:0]    ones_wide;
    logic [3:0]       tens_v;

    assign count_ext = {1'b0, count_q};
    assign data_ext  = {1'b0, data};
    assign count_inc = count_ext + ONE;
    assign count_dec = count_ext - ONE;

    // State and pulse registers; reset clears everything immediately, killing any pulse.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            count_q    <= '0;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            carry_q    <= carry_d;
            borrow_q   <= borrow_d;
            load_err_q <= load_err_d;
        end
    end

    // Next-state: load beats tick; pulses are one-hot by construction of the branches.
    always_comb begin
        count_d    = count_q;
        carry_d    = 1'b0;
        borrow_d   = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (data_ext < MOD_EXT) begin
                count_d = data;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (tick) begin
            if (up) begin
                if (count_ext == MOD_LAST) begin
                    count_d = '0;
                    carry_d = 1'b1;
                end else begin
                    count_d = count_inc[WIDTH-1:0];
                end
            end else begin
                if (count_ext == '0) begin
                    count_d  = MOD_LAST[WIDTH-1:0];
                    borrow_d = 1'b1;
                end else begin
                    count_d = count_dec[WIDTH-1:0];
                end
            end
        end
    end

    assign hour12 = (HOUR_MODE != 0) && mode_12h;

    // Display value: 12-hour mapping shows midnight/noon hour as 12, afternoon as 1..11.
    always_comb begin
        disp_ext = count_ext;
        if (hour12) begin
            if (count_ext == '0) begin
                disp_ext = TWELVE;
            end else if (count_ext > TWELVE) begin
                disp_ext = count_ext - TWELVE;
            end
        end
    end

    // Decimal split of the display value (always below 100).
    always_comb begin
        disp_wide            = '0;
        disp_wide[WIDTH:0]   = disp_ext;
        tens_v               = 4'd0;
        for (int unsigned i = 1; i < 10; i++) begin
            if (disp_wide >= DW'(i * 10)) begin
                tens_v = 4'(i);
            end
        end
        ones_wide = disp_wide - DW'(tens_v * 10);
    end

    // Upper bits of the wide intermediates are zero by construction.
    logic unused_bits;
    assign unused_bits = ^{ones_wide[DW-1:4], disp_ext[WIDTH], count_inc[WIDTH], count_dec[WIDTH]};

    assign count    = count_q;
    assign databus  = enable ? disp_ext[WIDTH-1:0] : '0;
    assign bcd_tens = tens_v;
    assign bcd_ones = ones_wide[3:0];
    assign pm       = hour12 && (count_ext >= TWELVE);
    assign carry    = carry_q;
    assign borrow   = borrow_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_time_unit_counter.sv
// Directed bench for time_unit_counter: a 24-hour instance and a 60-count instance.
module tb_time_unit_counter;

    logic       clk;
    logic       clear_n;
    logic       tick, up, load, enable, mode_12h;
    logic [4:0] data;
    logic [4:0] count, databus;
    logic [3:0] bcd_tens, bcd_ones;
    logic       pm, carry, borrow, load_err;

    logic       tick60, load60, mode60;
    logic [5:0] data60;
    logic [5:0] count60, databus60;
    logic [3:0] tens60, ones60;
    logic       pm60, carry60, borrow60, load_err60;

    int checks;
    int failures;

    time_unit_counter u_dut (
        .clk      (clk),
        .clear_n  (clear_n),
        .tick     (tick),
        .up       (up),
        .load     (load),
        .data     (data),
        .enable   (enable),
        .mode_12h (mode_12h),
        .count    (count),
        .databus  (databus),
        .bcd_tens (bcd_tens),
        .bcd_ones (bcd_ones),
        .pm       (pm),
        .carry    (carry),
        .borrow   (borrow),
        .load_err (load_err)
    );

    time_unit_counter #(
        .WIDTH     (6),
        .MODULUS   (60),
        .HOUR_MODE (0)
    ) u_dut60 (
        .clk      (clk),
        .clear_n  (clear_n),
        .tick     (tick60),
        .up       (up),
        .load     (load60),
        .data     (data60),
        .enable   (enable),
        .mode_12h (mode60),
        .count    (count60),
        .databus  (databus60),
        .bcd_tens (tens60),
        .bcd_ones (ones60),
        .pm       (pm60),
        .carry    (carry60),
        .borrow   (borrow60),
        .load_err (load_err60)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear_n  = 1'b0;
        tick = 1'b0; up = 1'b1; load = 1'b0; data = '0;
        enable = 1'b1; mode_12h = 1'b0;
        tick60 = 1'b0; load60 = 1'b0; data60 = '0; mode60 = 1'b0;

        // Reset state
        step();
        check("rst_count", count, 0);
        check("rst_carry", carry, 0);
        check("rst_borrow", borrow, 0);
        check("rst_load_err", load_err, 0);
        check("rst_databus_24h", databus, 0);
        mode_12h = 1'b1;
        #1;
        check("rst_databus_12h", databus, 12);
        check("rst_pm_12h", pm, 0);
        mode_12h = 1'b0;

        // Count up 25 ticks: 1..23, 0 (carry), 1
        clear_n = 1'b1;
        tick    = 1'b1;
        up      = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            step();
            check($sformatf("up_count_%0d", k), count, k % 24);
            check($sformatf("up_carry_%0d", k), carry, (k == 24) ? 1 : 0);
        end
        tick = 1'b0;

        // Load 0 then count down once -> 23 with borrow
        load = 1'b1; data = 5'd0;
        step();
        check("load0_count", count, 0);
        check("load0_carry", carry, 0);
        check("load0_borrow", borrow, 0);
        load = 1'b0; up = 1'b0; tick = 1'b1;
        step();
        check("down_wrap_count", count, 23);
        check("down_wrap_borrow", borrow, 1);
        check("down_wrap_carry", carry, 0);
        tick = 1'b0;
        step();
        check("down_hold_count", count, 23);
        check("down_borrow_clear", borrow, 0);

        // Rejected load, then load overriding a tick
        load = 1'b1; data = 5'd5;
        step();
        check("load5_count", count, 5);
        data = 5'd30;
        step();
        check("badload_count", count, 5);
        check("badload_err", load_err, 1);
        check("badload_carry", carry, 0);
        load = 1'b0;
        step();
        check("badload_err_clear", load_err, 0);
        check("badload_hold", count, 5);
        load = 1'b1; data = 5'd7; tick = 1'b1; up = 1'b1;
        step();
        check("load_beats_tick", count, 7);
        check("load_tick_err", load_err, 0);
        load = 1'b0; tick = 1'b0;

        // 12-hour display mapping
        load = 1'b1; data = 5'd0;
        step();
        mode_12h = 1'b1;
        #1;
        check("h0_databus", databus, 12);
        check("h0_tens", bcd_tens, 1);
        check("h0_ones", bcd_ones, 2);
        check("h0_pm", pm, 0);
        data = 5'd13;
        step();
        check("h13_databus", databus, 1);
        check("h13_tens", bcd_tens, 0);
        check("h13_ones", bcd_ones, 1);
        check("h13_pm", pm, 1);
        check("h13_count", count, 13);
        data = 5'd12;
        step();
        load = 1'b0;
        check("h12_databus", databus, 12);
        check("h12_tens", bcd_tens, 1);
        check("h12_ones", bcd_ones, 2);
        check("h12_pm", pm, 1);
        enable = 1'b0;
        #1;
        check("h12_gated_databus", databus, 0);
        check("h12_gated_tens", bcd_tens, 1);
        check("h12_gated_ones", bcd_ones, 2);
        mode_12h = 1'b0;
        enable   = 1'b1;
        #1;
        check("h12_24h_pm", pm, 0);
        check("h12_24h_count", count, 12);
        load = 1'b1; data = 5'd23;
        step();
        load = 1'b0;
        check("h23_24h_databus", databus, 23);
        check("h23_24h_tens", bcd_tens, 2);
        check("h23_24h_ones", bcd_ones, 3);
        mode_12h = 1'b1;
        #1;
        check("h23_12h_databus", databus, 11);
        check("h23_12h_count", count, 23);
        mode_12h = 1'b0;

        // Reset mid-pulse: count at 23, wrap up -> carry, then clear between edges
        tick = 1'b1; up = 1'b1;
        step();
        tick = 1'b0;
        check("pre_rst_carry", carry, 1);
        #2;
        clear_n = 1'b0;
        #1;
        check("mid_rst_carry", carry, 0);
        check("mid_rst_count", count, 0);
        #1;
        clear_n = 1'b1;
        tick    = 1'b1;
        step();
        tick = 1'b0;
        check("post_rst_count", count, 1);
        check("post_rst_carry", carry, 0);

        // 60-count instance, no hour mode: 61 ticks, mode60 toggled throughout
        tick60 = 1'b1; up = 1'b1;
        for (int k = 1; k <= 61; k++) begin
            mode60 = k[0];
            step();
            check($sformatf("m60_count_%0d", k), count60, k % 60);
            check($sformatf("m60_carry_%0d", k), carry60, (k == 60) ? 1 : 0);
            check($sformatf("m60_databus_%0d", k), databus60, k % 60);
            check($sformatf("m60_pm_%0d", k), pm60, 0);
        end
        tick60 = 1'b0;
        load60 = 1'b1; data60 = 6'd59; mode60 = 1'b1;
        step();
        check("m60_load59_tens", tens60, 5);
        check("m60_load59_ones", ones60, 9);
        data60 = 6'd60;
        step();
        load60 = 1'b0;
        check("m60_badload_err", load_err60, 1);
        check("m60_badload_count", count60, 59);
        check("m60_borrow", borrow60, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
